// File: rtl/arm_imm_encoder_pkg.sv
// arm_imm_encoder_pkg: shared states, rotation count and imm12 field layout
package arm_imm_encoder_pkg;
  localparam int NUM_ROTS = 16;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  typedef struct packed {
    logic [3:0] rot;
    logic [7:0] imm8;
  } imm12_t;
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] d;
    d = {v, v} << n;
    return d[63:32];
  endfunction
endpackage

// File: rtl/arm_imm_encoder_rot_hit.sv
// arm_imm_encoder_rot_hit: lowest rotation in a group that brings cand into imm8 range
module arm_imm_encoder_rot_hit
  import arm_imm_encoder_pkg::*;
#(
  parameter int ROTS_PER_CYCLE = 1
) (
  input  logic [31:0] cand_i,
  input  logic [3:0]  base_i,
  output logic        hit_o,
  output logic [3:0]  off_o,
  output logic [7:0]  imm8_o
);
  logic [31:0] rc;
  always_comb begin
    hit_o = 1'b0;
    off_o = '0;
    imm8_o = '0;
    rc = '0;
    for (int k = ROTS_PER_CYCLE - 1; k >= 0; k--) begin
      rc = rol32(cand_i, {base_i + 4'(k), 1'b0});
      if (rc[31:8] == 24'd0) begin
        hit_o = 1'b1;
        off_o = 4'(k);
        imm8_o = rc[7:0];
      end
    end
  end
endmodule

// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder: iterative search for the ARM rotated-imm8 encoding of a constant
module arm_imm_encoder
  import arm_imm_encoder_pkg::*;
#(
  parameter int ROTS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  input  logic        try_inv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        found,
  output logic        inv,
  output logic [11:0] imm12
);
  state_t      state_q, state_d;
  logic [31:0] cand_q, cand_d;
  logic [3:0]  rot_q, rot_d;
  logic        phase_q, phase_d, try_inv_q, try_inv_d;
  logic        found_q, found_d, inv_q, inv_d;
  imm12_t      imm12_q, imm12_d;
  logic        hit, last;
  logic [3:0]  off;
  logic [7:0]  imm8;

  arm_imm_encoder_rot_hit #(.ROTS_PER_CYCLE(ROTS_PER_CYCLE)) u_rot_hit (
    .cand_i(cand_q),
    .base_i(rot_q),
    .hit_o(hit),
    .off_o(off),
    .imm8_o(imm8)
  );

  assign last = ({1'b0, rot_q} + 5'(ROTS_PER_CYCLE)) >= 5'(NUM_ROTS);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign found = found_q;
  assign inv = inv_q;
  assign imm12 = imm12_q;

  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    rot_d = rot_q;
    phase_d = phase_q;
    try_inv_d = try_inv_q;
    found_d = found_q;
    inv_d = inv_q;
    imm12_d = imm12_q;
    case (state_q)
      IDLE: if (in_valid) begin
        cand_d = value;
        try_inv_d = try_inv;
        rot_d = '0;
        phase_d = 1'b0;
        state_d = SEARCH;
      end
      SEARCH: if (hit) begin
        found_d = 1'b1;
        inv_d = phase_q;
        imm12_d = '{rot: rot_q + off, imm8: imm8};
        state_d = DONE;
      end else if (!last) begin
        rot_d = rot_q + 4'(ROTS_PER_CYCLE);
      end else if (try_inv_q && !phase_q) begin
        cand_d = ~cand_q;
        rot_d = '0;
        phase_d = 1'b1;
      end else begin
        found_d = 1'b0;
        inv_d = 1'b0;
        imm12_d = '0;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cand_q <= '0;
      rot_q <= '0;
      phase_q <= 1'b0;
      try_inv_q <= 1'b0;
      found_q <= 1'b0;
      inv_q <= 1'b0;
      imm12_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      rot_q <= rot_d;
      phase_q <= phase_d;
      try_inv_q <= try_inv_d;
      found_q <= found_d;
      inv_q <= inv_d;
      imm12_q <= imm12_d;
    end
  end
endmodule
